// File: rtl/result_tx_pkg.sv
// -----------------------------------------------------------------------------
// result_tx_pkg
// Shared types and line levels for the ALU result serial transmitter.
//   tx_state_t : transmitter FSM states. The PARITY state exists only when
//                RESULT_TX_PARITY_EN is defined.
//   START_LVL  : line level of the start bit.
//   STOP_LVL   : line level of the stop bit.
//   IDLE_LVL   : line level while no frame is being sent.
// -----------------------------------------------------------------------------
package result_tx_pkg;

`ifdef RESULT_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
`endif

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/result_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// result_tx_bit_timer
// Bit-period timer for the result serializer. Counts clock cycles within one
// serial bit and pulses bit_done in the last cycle of each bit period.
//   clk      : clock, rising edge.
//   reset    : asynchronous, active-high reset.
//   restart  : holds the counter at zero (used while the line is idle so the
//              first bit of a frame always gets a full period).
//   bit_done : high during the final cycle of a bit period.
// Parameter CLKS_PER_BIT (>= 1) sets the period length.
// -----------------------------------------------------------------------------
module result_tx_bit_timer
  import result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Suppressed during restart so the FSM never sees a stale boundary.
  assign bit_done = !restart && (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/result_tx_serializer.sv
// -----------------------------------------------------------------------------
// result_tx_serializer
// Parallel-to-serial transmitter for ALU result words. A word captured on
// load waits in a one-entry holding register, then is sent as
// start bit, DATA_W data bits LSB first, optional even parity bit, stop bit,
// each bit held CLKS_PER_BIT cycles. A word waiting in the holding register
// when a stop bit ends is started immediately, with no idle gap.
//
// Optional feature: define RESULT_TX_PARITY_EN to insert an even-parity bit
// (XOR of the data bits) between the MSB and the stop bit.
//
// Ports
//   clk         : clock, rising edge.
//   reset       : asynchronous, active-high reset; abandons any frame and
//                 discards the held word.
//   in_data     : result word to transmit.
//   load        : capture strobe; accepted only while ready is high.
//   clr_overrun : synchronous clear of overrun (a new overrun wins).
//   ready       : holding register empty (registered).
//   busy        : a frame is on the line (registered).
//   tx          : serial line (registered), idles high.
//   overrun     : sticky, set when load arrives while ready is low.
// -----------------------------------------------------------------------------
module result_tx_serializer
  import result_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              load,
  input  logic              clr_overrun,
  output logic              ready,
  output logic              busy,
  output logic              tx,
  output logic              overrun
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state;
  logic [BIT_W-1:0]  bit_idx;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] shift;
`ifdef RESULT_TX_PARITY_EN
  logic              parity_bit;
`endif

  logic bit_done;
  logic timer_restart;
  logic xfer;
  logic accept;
  logic drop;

  // The timer sits at zero while idle, so START always lasts a full period.
  assign timer_restart = (state == IDLE);

  // Holding register drains into the shift register either from idle or at
  // the very end of a stop bit (back-to-back frames).
  assign xfer   = hold_valid && ((state == IDLE) || ((state == STOP) && bit_done));
  // ready is the registered complement of hold_valid, so a load in the
  // transfer cycle still sees ready low and counts as an overrun.
  assign accept = load && ready;
  assign drop   = load && !ready;

  result_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (timer_restart),
    .bit_done(bit_done)
  );

  // Holding register control and overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      ready      <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      if (xfer) begin
        hold_valid <= 1'b0;
        ready      <= 1'b1;
      end else if (accept) begin
        hold_valid <= 1'b1;
        ready      <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  // Data registers: contents are only meaningful while qualified by
  // hold_valid / the FSM state, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= in_data;
    end

    if (xfer) begin
      shift <= hold_data;
    end else if ((state == DATA) && bit_done && (bit_idx != LAST_BIT)) begin
      shift <= shift >> 1;
    end

`ifdef RESULT_TX_PARITY_EN
    if (xfer) begin
      parity_bit <= ^hold_data;
    end
`endif
  end

  // Frame sequencing; tx and busy are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      tx      <= IDLE_LVL;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hold_valid) begin
            state <= START;
            tx    <= START_LVL;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
`ifdef RESULT_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= STOP_LVL;
`endif
            end else begin
              // shift[1] becomes the LSB on this same edge.
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end
        end

`ifdef RESULT_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
            tx    <= STOP_LVL;
          end
        end
`endif

        STOP: begin
          if (bit_done) begin
            bit_idx <= '0;
            if (hold_valid) begin
              state <= START;
              tx    <= START_LVL;
            end else begin
              state <= IDLE;
              tx    <= IDLE_LVL;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          bit_idx <= '0;
          tx      <= IDLE_LVL;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
